// File: rtl/cas_pkg.sv
// Shared types and constants for the cassette FSK transmitter.
// Holds the frame state encoding, the default timing constants and the frame shape.
package cas_pkg;

  typedef enum logic [2:0] {
    CAS_IDLE   = 3'd0,
    CAS_HEADER = 3'd1,
    CAS_START  = 3'd2,
    CAS_DATA   = 3'd3,
    CAS_STOP   = 3'd4
  } cas_state_e;

  // Defaults assume a 3.58 MHz enable: 1200 Hz for a 0-bit, 2400 Hz for a 1-bit.
  localparam int DEF_HALF0     = 1491;
  localparam int DEF_HALF1     = 746;
  localparam int DEF_LONG_HDR  = 8000;
  localparam int DEF_SHORT_HDR = 2000;

  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 2;

  localparam int HALF_W = 11;
  localparam int BIT_W  = 4;
  localparam int HDR_W  = 14;

endpackage

// File: rtl/cas_fsk_bitgen.sv
// Single-bit FSK waveform generator: a 0-bit is one low/high period at HALF0,
// a 1-bit is two low/high periods at HALF1. Always starts with a low half.
module cas_fsk_bitgen
  import cas_pkg::*;
#(
  parameter int HALF0 = DEF_HALF0,
  parameter int HALF1 = DEF_HALF1
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clk_en_i,
  input  logic abort_i,
  input  logic start_i,
  input  logic bit_i,
  output logic level_o,
  output logic done_o
);

  localparam logic [HALF_W-1:0] H0_CNT  = HALF_W'(HALF0);
  localparam logic [HALF_W-1:0] H1_CNT  = HALF_W'(HALF1);
  localparam logic [HALF_W-1:0] CNT_ONE = HALF_W'(1);

  logic [HALF_W-1:0] half_cnt;
  logic [1:0]        half_idx;
  logic              bit_q;
  logic              active;
  logic              last_half;
  logic              half_end;

  assign last_half = bit_q ? (half_idx == 2'd3) : (half_idx == 2'd1);
  assign half_end  = active & clk_en_i & (half_cnt == CNT_ONE);
  assign done_o    = half_end & last_half;

  // A start in the same cycle as done restarts seamlessly, so frames have no gaps.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      half_cnt <= '0;
      half_idx <= '0;
      bit_q    <= 1'b0;
      active   <= 1'b0;
      level_o  <= 1'b0;
    end else if (abort_i) begin
      half_cnt <= '0;
      half_idx <= '0;
      active   <= 1'b0;
      level_o  <= 1'b0;
    end else if (start_i) begin
      half_cnt <= bit_i ? H1_CNT : H0_CNT;
      half_idx <= '0;
      bit_q    <= bit_i;
      active   <= 1'b1;
      level_o  <= 1'b0;
    end else if (half_end) begin
      if (last_half) begin
        half_cnt <= '0;
        half_idx <= '0;
        active   <= 1'b0;
        level_o  <= 1'b0;
      end else begin
        half_cnt <= bit_q ? H1_CNT : H0_CNT;
        half_idx <= half_idx + 2'd1;
        level_o  <= ~level_o;
      end
    end else if (active && clk_en_i) begin
      half_cnt <= half_cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/cas_fsk_tx.sv
// Cassette FSK transmitter: frames bytes (start, 8 data LSB first, 2 stop) and,
// with CAS_TX_HEADER_EN defined, sends runs of 1-bit header tone.
//
// state  | meaning
// IDLE   | waiting for a byte or header request (ready when motor on)
// HEADER | sending the loaded number of 1-bits
// START  | sending the 0 start bit
// DATA   | sending data bits LSB first
// STOP   | sending the two 1 stop bits
module cas_fsk_tx
  import cas_pkg::*;
#(
  parameter int HALF0     = DEF_HALF0,
  parameter int HALF1     = DEF_HALF1,
  parameter int LONG_HDR  = DEF_LONG_HDR,
  parameter int SHORT_HDR = DEF_SHORT_HDR
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       clk_en_i,
  input  logic       motor_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       header_i,
  input  logic       header_long_i,
  output logic       busy_o,
  output logic       cas_out_o
);

  localparam logic [2:0] S_IDLE   = CAS_IDLE;
  localparam logic [2:0] S_START  = CAS_START;
  localparam logic [2:0] S_DATA   = CAS_DATA;
  localparam logic [2:0] S_STOP   = CAS_STOP;

  localparam logic [BIT_W-1:0] START_LAST = BIT_W'(START_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);

  logic [2:0]       state, state_d;
  logic [7:0]       data_q;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_d;
  logic             accept_byte;
  logic             accept_hdr;
  logic             abort;
  logic             bg_start;
  logic             bg_bit;
  logic             bit_done;

  assign ready_o = (state == S_IDLE) & motor_i;
  assign busy_o  = (state != S_IDLE);
  assign abort   = busy_o & ~motor_i;

`ifdef CAS_TX_HEADER_EN
  localparam logic [2:0]       S_HEADER  = CAS_HEADER;
  localparam logic [HDR_W-1:0] LONG_CNT  = HDR_W'(LONG_HDR);
  localparam logic [HDR_W-1:0] SHORT_CNT = HDR_W'(SHORT_HDR);
  localparam logic [HDR_W-1:0] HDR_ONE   = HDR_W'(1);

  logic [HDR_W-1:0] hdr_cnt, hdr_cnt_d;

  assign accept_hdr = ready_o & header_i;
`else
  logic unused_hdr;

  assign accept_hdr = 1'b0;
  assign unused_hdr = header_i ^ header_long_i ^ (LONG_HDR != SHORT_HDR);
`endif

  // A header request wins over a simultaneous byte; the byte source keeps valid_i up.
  assign accept_byte = ready_o & valid_i & ~accept_hdr;

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    bg_start  = 1'b0;
    bg_bit    = 1'b0;
`ifdef CAS_TX_HEADER_EN
    hdr_cnt_d = hdr_cnt;
`endif
    if (abort) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
`ifdef CAS_TX_HEADER_EN
      hdr_cnt_d = '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
`ifdef CAS_TX_HEADER_EN
          if (accept_hdr) begin
            state_d   = S_HEADER;
            hdr_cnt_d = header_long_i ? LONG_CNT : SHORT_CNT;
            bg_start  = 1'b1;
            bg_bit    = 1'b1;
          end else
`endif
          if (accept_byte) begin
            state_d   = S_START;
            bit_cnt_d = '0;
            bg_start  = 1'b1;
            bg_bit    = 1'b0;
          end
        end
`ifdef CAS_TX_HEADER_EN
        S_HEADER: begin
          if (bit_done) begin
            if (hdr_cnt <= HDR_ONE) begin
              state_d   = S_IDLE;
              hdr_cnt_d = '0;
            end else begin
              hdr_cnt_d = hdr_cnt - HDR_ONE;
              bg_start  = 1'b1;
              bg_bit    = 1'b1;
            end
          end
        end
`endif
        S_START: begin
          if (bit_done) begin
            bg_start = 1'b1;
            if (bit_cnt == START_LAST) begin
              state_d   = S_DATA;
              bit_cnt_d = '0;
              bg_bit    = data_q[0];
            end else begin
              bit_cnt_d = bit_cnt + BIT_ONE;
              bg_bit    = 1'b0;
            end
          end
        end
        S_DATA: begin
          if (bit_done) begin
            bg_start = 1'b1;
            if (bit_cnt == DATA_LAST) begin
              state_d   = S_STOP;
              bit_cnt_d = '0;
              bg_bit    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt + BIT_ONE;
              bg_bit    = data_q[bit_cnt_d[2:0]];
            end
          end
        end
        S_STOP: begin
          if (bit_done) begin
            if (bit_cnt == STOP_LAST) begin
              state_d   = S_IDLE;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt + BIT_ONE;
              bg_start  = 1'b1;
              bg_bit    = 1'b1;
            end
          end
        end
        default: begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      data_q  <= 8'h00;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      if (accept_byte) begin
        data_q <= data_i;
      end
    end
  end

`ifdef CAS_TX_HEADER_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hdr_cnt <= '0;
    end else begin
      hdr_cnt <= hdr_cnt_d;
    end
  end
`endif

  cas_fsk_bitgen #(
    .HALF0(HALF0),
    .HALF1(HALF1)
  ) u_bitgen (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clk_en_i (clk_en_i),
    .abort_i  (abort),
    .start_i  (bg_start),
    .bit_i    (bg_bit),
    .level_o  (cas_out_o),
    .done_o   (bit_done)
  );

endmodule

// File: tb/tb_cas_fsk_tx.sv
// Self-checking bench for cas_fsk_tx with short half-periods; expected waveforms
// are built as per-enable level lists from the bit/frame rules.
module tb_cas_fsk_tx;

  localparam int H0 = 7;
  localparam int H1 = 3;
  localparam int LH = 6;
  localparam int SH = 3;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       clk_en_i = 1'b0;
  logic       motor_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       header_i = 1'b0;
  logic       header_long_i = 1'b0;
  logic       ready_o;
  logic       busy_o;
  logic       cas_out_o;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int obs_q[$];
  int busy_en;

  cas_fsk_tx #(
    .HALF0(H0),
    .HALF1(H1),
    .LONG_HDR(LH),
    .SHORT_HDR(SH)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .clk_en_i     (clk_en_i),
    .motor_i      (motor_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .header_i     (header_i),
    .header_long_i(header_long_i),
    .busy_o       (busy_o),
    .cas_out_o    (cas_out_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int bit_len(input bit b);
    return b ? 4 * H1 : 2 * H0;
  endfunction

  function automatic void push_bit(input bit b);
    if (!b) begin
      repeat (H0) exp_q.push_back(0);
      repeat (H0) exp_q.push_back(1);
    end else begin
      repeat (2) begin
        repeat (H1) exp_q.push_back(0);
        repeat (H1) exp_q.push_back(1);
      end
    end
  endfunction

  function automatic void model_byte(input logic [7:0] d);
    exp_q.delete();
    push_bit(1'b0);
    for (int i = 0; i < 8; i++) push_bit(d[i]);
    push_bit(1'b1);
    push_bit(1'b1);
  endfunction

  function automatic void model_header(input int n);
    exp_q.delete();
    repeat (n) push_bit(1'b1);
  endfunction

  function automatic logic [10:0] decode_obs();
    logic [10:0] seq;
    int idx;
    int r;
    seq = '0;
    idx = 0;
    while (idx < obs_q.size()) begin
      r = 0;
      while (idx + r < obs_q.size() && obs_q[idx + r] == 0) r++;
      seq = {seq[9:0], (r != H0)};
      idx += (r == H0) ? 2 * H0 : 4 * H1;
    end
    return seq;
  endfunction

  // Issue a request at the current negedge and follow the frame enable by enable.
  task automatic send(input string tag, input logic [7:0] d, input bit hdr, input bit hdr_long,
                      input bit keep_valid, input int en_pct, input int abort_k, input int rst_k);
    int n, k, cyc;
    bit en;
    n = exp_q.size();
    k = 0;
    cyc = 0;
    busy_en = 0;
    obs_q.delete();
    check_val({tag, "_ready"}, ready_o, 1);
    data_i = d;
    if (hdr) begin
      header_i = 1'b1;
      header_long_i = hdr_long;
      valid_i = keep_valid;
    end else begin
      valid_i = 1'b1;
`ifndef CAS_TX_HEADER_EN
      header_i = 1'b1;
`endif
    end
    clk_en_i = 1'($urandom_range(0, 1));
    @(negedge clk_i);
    header_i = 1'b0;
    if (!keep_valid) valid_i = 1'b0;
    check_val({tag, "_busy0"}, busy_o, 1);
    check_val({tag, "_out0"}, cas_out_o, exp_q[0]);
    while (k < n && cyc < 20 * n + 100) begin
      if (k == abort_k) begin
        valid_i = 1'b0;
        header_i = 1'b0;
        motor_i = 1'b0;
        @(negedge clk_i);
        check_val({tag, "_abort_busy"}, busy_o, 0);
        check_val({tag, "_abort_out"}, cas_out_o, 0);
        check_val({tag, "_abort_ready"}, ready_o, 0);
        repeat (4) @(negedge clk_i);
        check_val({tag, "_abort_ready_hold"}, ready_o, 0);
        motor_i = 1'b1;
        clk_en_i = 1'b0;
        #1;
        check_val({tag, "_abort_ready_back"}, ready_o, 1);
        @(negedge clk_i);
        return;
      end
      if (k == rst_k) begin
        valid_i = 1'b0;
        header_i = 1'b0;
        #2 reset_n_i = 1'b0;
        #1;
        check_val({tag, "_rst_busy"}, busy_o, 0);
        check_val({tag, "_rst_out"}, cas_out_o, 0);
        check_val({tag, "_rst_ready"}, ready_o, 1);
        @(negedge clk_i);
        clk_en_i = 1'b0;
        reset_n_i = 1'b1;
        return;
      end
      en = ($urandom_range(0, 99) < en_pct);
      clk_en_i = en;
      if (!keep_valid) begin
        valid_i = 1'($urandom_range(0, 1));
        data_i = 8'($urandom);
      end
      header_i = 1'($urandom_range(0, 1));
      if (en) begin
        obs_q.push_back(int'(cas_out_o));
        if (busy_o) busy_en++;
      end
      @(negedge clk_i);
      cyc++;
      if (en) k++;
      if (k < n) begin
        check_val({tag, "_busy"}, busy_o, 1);
        check_val({tag, "_out"}, cas_out_o, exp_q[k]);
      end
    end
    check_val({tag, "_len"}, k, n);
    clk_en_i = 1'b0;
    header_i = 1'b0;
    if (!keep_valid) valid_i = 1'b0;
    check_val({tag, "_end_busy"}, busy_o, 0);
    check_val({tag, "_end_out"}, cas_out_o, 0);
    check_val({tag, "_end_ready"}, ready_o, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int ak, rk;
    motor_i = 1'b1;
    @(negedge clk_i);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_out", cas_out_o, 0);
    check_val("rst_ready", ready_o, 1);
    motor_i = 1'b0;
    #1;
    check_val("rst_ready_motor_off", ready_o, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    valid_i = 1'b1;
    clk_en_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_val("motor_off_ignore_busy", busy_o, 0);
    valid_i = 1'b0;
    clk_en_i = 1'b0;
    motor_i = 1'b1;
    @(negedge clk_i);

    model_byte(8'h00);
    send("b00", 8'h00, 0, 0, 0, 100, -1, -1);
    check_val("b00_busy_enables", busy_en, 9 * 2 * H0 + 2 * 4 * H1);

    model_byte(8'hA5);
    send("bA5", 8'hA5, 0, 0, 0, 60, -1, -1);
    check_val("bA5_decode", decode_obs(), 11'b01010010111);

    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      model_byte(d);
      send($sformatf("rnd%0d", i), d, 0, 0, 0, $urandom_range(30, 100), -1, -1);
    end

    d = 8'h3C;
    model_byte(d);
    ak = 2 * H0 + bit_len(d[0]) + bit_len(d[1]) + bit_len(d[2]) + 2;
    send("abort", d, 0, 0, 0, 70, ak, -1);
    model_byte(8'h5A);
    send("post_abort", 8'h5A, 0, 0, 0, 70, -1, -1);

    d = 8'h96;
    model_byte(d);
    rk = 2 * H0 + 3;
    for (int i = 0; i < 8; i++) rk += bit_len(d[i]);
    send("rst_stop", d, 0, 0, 0, 70, -1, rk);
    model_byte(8'hC3);
    send("post_rst", 8'hC3, 0, 0, 0, 70, -1, -1);

`ifdef CAS_TX_HEADER_EN
    model_header(SH);
    send("hdr_short", 8'h00, 1, 0, 0, 80, -1, -1);
    model_header(LH);
    send("hdr_long", 8'h00, 1, 1, 0, 80, -1, -1);
    model_header(SH);
    send("hdr_valid", 8'h71, 1, 0, 1, 80, -1, -1);
    model_byte(8'h71);
    send("hdr_valid_byte", 8'h71, 0, 0, 0, 80, -1, -1);
    model_header(SH);
    send("hdr_drop", 8'h0F, 1, 0, 0, 80, -1, -1);
    repeat (3) @(negedge clk_i);
    check_val("hdr_drop_idle", busy_o, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cas_fsk_tx.md
CAS_FSK_TX -- requirements
Module: cas_fsk_tx

Interface
REQ-001 Parameter HALF0, default 1491: clk_en_i pulses per half-period of a 0-bit, which is 1200 Hz at 3.58 MHz.
REQ-002 Parameter HALF1, default 746: clk_en_i pulses per half-period of a 1-bit, which is 2400 Hz.
REQ-003 Parameter LONG_HDR, default 8000: number of 1-bits in a long header.
REQ-004 Parameter SHORT_HDR, default 2000: number of 1-bits in a short header.
REQ-005 clk_i  in  1  system clock; the block has one clock only.
REQ-006 reset_n_i  in  1  reset, asynchronous, active-low.
REQ-007 clk_en_i  in  1  3.58 MHz clock-enable pulse, one clk_i cycle wide.
REQ-008 motor_i  in  1  cassette motor on (PPI port C bit 4).
REQ-009 data_i  in  8  byte to transmit.
REQ-010 valid_i  in  1  data_i valid.
REQ-011 ready_o  out  1  block can accept a byte or a header request.
REQ-012 header_i  in  1  header request, qualified by ready_o.
REQ-013 header_long_i  in  1  header length select: 1 = LONG_HDR, 0 = SHORT_HDR; sampled together with header_i.
REQ-014 busy_o  out  1  transmission in progress.
REQ-015 cas_out_o  out  1  FSK square-wave output (CASW).

Function
REQ-016 States: IDLE, HEADER, START, DATA, STOP.
REQ-017 ready_o = (state==IDLE) & motor_i.
REQ-018 busy_o = (state!=IDLE).
REQ-019 A byte is accepted when valid_i & ready_o on any clk_i edge; data_i is latched and the state goes to START.
REQ-020 A header request is accepted when header_i & ready_o; the header count is loaded and the state goes to HEADER.
REQ-021 When header_i and valid_i are asserted in the same cycle, the header is accepted and the byte is not (valid_i is held by the source).
REQ-022 0-bit waveform: cas_out_o low for HALF0 enables, then high for HALF0 enables.
REQ-023 1-bit waveform: low for HALF1, high for HALF1, low for HALF1, high for HALF1 enables.
REQ-024 Byte frame: one start bit (0), then 8 data bits LSB first (DATA state), then two stop bits (1, STOP state).
REQ-025 HEADER sends the loaded count of 1-bits, then returns to IDLE.
REQ-026 The first low half of a frame starts at the first clk_en_i after acceptance; cas_out_o changes only on clk_en_i cycles.
REQ-027 After the last high half of the frame, the state returns to IDLE on that same clk_en_i edge, and cas_out_o is driven to 0.
REQ-028 Back-to-back bytes: ready_o is high in the cycle after frame end, so there is no gap beyond one clk_i between frames.
REQ-029 Half-period counter: 11 bits, counting down to 1; reload on toggle. Bit counter: 4 bits. Header counter: 14 bits, saturating at 0.
REQ-030 If motor_i falls in any non-IDLE state, the next clk_i goes to IDLE, cas_out_o=0, and the current byte or header is discarded.
REQ-031 valid_i and header_i are ignored while ready_o=0.

Reset
REQ-032 While reset_n_i=0: state=IDLE, all counters 0, the data latch is 0x00, cas_out_o=0, busy_o=0; ready_o follows REQ-017.
REQ-033 Reset asserted mid-frame aborts immediately; there is no residual output after reset deasserts.

Configuration
REQ-034 Macro CAS_TX_HEADER_EN. When defined: the HEADER state, the header counter, and the header_i / header_long_i logic are present.
REQ-035 When CAS_TX_HEADER_EN is not defined: the header_i and header_long_i ports remain but are ignored, the HEADER state is absent, and only byte frames are sent.

Structure
REQ-036 Shared package cas_pkg holds:
- the state enum;
- the default HALF0, HALF1, LONG_HDR and SHORT_HDR constants;
- the frame constants START_BITS=1, DATA_BITS=8, STOP_BITS=2.
REQ-037 One sub-module, cas_fsk_bitgen, generates one bit's waveform.
- Inputs: bit value, start pulse.
- Outputs: level, done pulse.
- The frame and header sequencing stays in cas_fsk_tx.

Verification
REQ-038 motor_i=1, send byte 0x00 with clk_en_i every cycle:
- busy_o is high for exactly 9*2982 + 2*2984 = 32806 enables;
- cas_out_o shows 9 cycles at 1200 Hz followed by 4 cycles at 2400 Hz.
REQ-039 Send byte 0xA5: the decoded bit sequence is 0,1,0,1,0,0,1,0,1,1,1.
REQ-040 header_i=1 with header_long_i=0 (macro defined): 2000 one-bits = 8000 half-periods of 746 enables, then IDLE.
REQ-041 header_i and valid_i asserted in the same cycle: HEADER is entered, and the byte is sent afterwards only if valid_i is still held.
REQ-042 motor_i dropped midway through DATA bit 3: next cycle state=IDLE, cas_out_o=0, busy_o=0; ready_o stays 0 until motor_i returns.
REQ-043 reset_n_i pulsed low during STOP: all outputs go to their reset values asynchronously; after release, the next accepted byte transmits correctly from its start bit.
